// File: rtl/spi_slave_responder.sv
// SPI target serving a 16 x 16-bit register file over a CMD/ADDR/DUMMY/DATA frame.
// SPI pins are oversampled in clk_i; SCLK is never used as a clock.
module spi_slave_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RST_VAL     = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        spi_clk_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_sdi_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_oe_o,
  input  logic        loc_wr_en_i,
  input  logic [3:0]  loc_wr_addr_i,
  input  logic [15:0] loc_wr_data_i,
  input  logic [3:0]  loc_rd_addr_i,
  output logic [15:0] loc_rd_data_o,
  output logic        wr_done_o,
  output logic [3:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        rd_done_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  localparam logic [3:0] CMD_WR = 4'b1011;
  localparam logic [3:0] CMD_RD = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WR, S_RD, S_IGN
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sdi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [4:0]             r_rise_cnt;
  logic [3:0]             r_cmd, r_addr;
  logic [15:0]            r_wdata, r_shadow;
  logic                   r_ld_shadow;
  logic [15:0][15:0]      r_regs;

  logic       w_sclk_s, w_cs_s, w_sdi_s;
  logic       w_rise, w_fall, w_cs_rise, w_cs_fall;
  logic [3:0] w_cmd_nxt, w_bit_idx;
  logic       w_short, w_abort;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi_s   = r_sdi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk_s & ~r_sclk_d;
  assign w_fall    = ~w_sclk_s & r_sclk_d;
  assign w_cs_rise = w_cs_s & ~r_cs_d;
  assign w_cs_fall = ~w_cs_s & r_cs_d;
  assign w_cmd_nxt = {r_cmd[2:0], w_sdi_s};
  // Data bit i sits at rise_cnt = 10+i and maps to word position 15-i = 25-rise_cnt.
  assign w_bit_idx = 4'(5'd25 - r_rise_cnt);
  // rise_cnt <= 10 at CS_n rise means no data edge was seen.
  assign w_short   = (r_rise_cnt <= 5'd10);
  assign w_abort   = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DUMMY) ||
                     (r_state == S_IGN) || (((r_state == S_WR) || (r_state == S_RD)) && w_short);

  assign loc_rd_data_o = r_regs[loc_rd_addr_i];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sdi_sync  <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD:   if (w_rise && r_rise_cnt == 5'd3)
                   w_state_nxt = (w_cmd_nxt == CMD_WR || w_cmd_nxt == CMD_RD) ? S_ADDR : S_IGN;
        S_ADDR:  if (w_rise && r_rise_cnt == 5'd7) w_state_nxt = S_DUMMY;
        S_DUMMY: if (w_rise && r_rise_cnt == 5'd9)
                   w_state_nxt = (r_cmd == CMD_WR) ? S_WR : S_RD;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rise_cnt   <= '0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_shadow     <= '0;
      r_ld_shadow  <= 1'b0;
      r_regs       <= {16{RST_VAL}};
      spi_sdo_o    <= 1'b0;
      spi_sdo_oe_o <= 1'b0;
      wr_done_o    <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      rd_done_o    <= 1'b0;
      frame_err_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      wr_done_o   <= 1'b0;
      rd_done_o   <= 1'b0;
      frame_err_o <= 1'b0;
      r_ld_shadow <= 1'b0;

      if (loc_wr_en_i) r_regs[loc_wr_addr_i] <= loc_wr_data_i;

      if (w_cs_fall) begin
        r_rise_cnt <= '0;
        r_wdata    <= '0;
        busy_o     <= 1'b1;
      end else if (w_rise && !w_cs_s) begin
        if (r_rise_cnt != 5'd31) r_rise_cnt <= r_rise_cnt + 5'd1;
        if (r_rise_cnt < 5'd4)      r_cmd  <= w_cmd_nxt;
        else if (r_rise_cnt < 5'd8) r_addr <= {r_addr[2:0], w_sdi_s};
        if (r_rise_cnt == 5'd7) r_ld_shadow <= 1'b1;
        if (r_state == S_WR && r_rise_cnt <= 5'd25) r_wdata[w_bit_idx] <= w_sdi_s;
      end

      // Snapshot taken once; later local writes cannot disturb the in-flight read.
      if (r_ld_shadow) r_shadow <= r_regs[r_addr];

      if (w_fall && !w_cs_s && r_state == S_RD && r_rise_cnt >= 5'd10) begin
        spi_sdo_oe_o <= 1'b1;
        spi_sdo_o    <= (r_rise_cnt <= 5'd25) ? r_shadow[w_bit_idx] : 1'b0;
      end

      if (w_cs_rise) begin
        busy_o       <= 1'b0;
        spi_sdo_oe_o <= 1'b0;
        spi_sdo_o    <= 1'b0;
        // Placed after the local write so the SPI commit wins on an address collision.
        if (r_state == S_WR && !w_short) begin
          r_regs[r_addr] <= r_wdata;
          wr_addr_o      <= r_addr;
          wr_data_o      <= r_wdata;
          wr_done_o      <= 1'b1;
        end
        if (r_state == S_RD && !w_short) rd_done_o <= 1'b1;
        if (w_abort) frame_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench: acts as SPI master and local host, checks against hand-computed values.
module tb_spi_slave_responder;

  localparam int SYNC = 2;
  localparam time HALF = 80ns;

  logic        gclk = 1'b0;
  logic        grst_n;
  logic        sclk, cs_n, sdi;
  logic        sdo, sdo_oe;
  logic        loc_wr_en;
  logic [3:0]  loc_wr_addr, loc_rd_addr;
  logic [15:0] loc_wr_data, loc_rd_data;
  logic        wr_done, rd_done, frame_err, busy;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  int n_cmp = 0, n_bad = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0, n_busy_bad = 0;
  int b_wr, b_rd, b_err, b_oe;
  logic [15:0] rd;

  always #5ns gclk = ~gclk;

  spi_slave_responder #(.SYNC_STAGES(SYNC), .RST_VAL(16'h0000)) dut (
    .clk_i(gclk), .rstn_i(grst_n),
    .spi_clk_i(sclk), .spi_cs_n_i(cs_n), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .spi_sdo_oe_o(sdo_oe),
    .loc_wr_en_i(loc_wr_en), .loc_wr_addr_i(loc_wr_addr), .loc_wr_data_i(loc_wr_data),
    .loc_rd_addr_i(loc_rd_addr), .loc_rd_data_o(loc_rd_data),
    .wr_done_o(wr_done), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .rd_done_o(rd_done), .frame_err_o(frame_err), .busy_o(busy)
  );

  always @(negedge gclk) begin
    if (wr_done) n_wr++;
    if (rd_done) n_rd++;
    if (frame_err) n_err++;
    if (sdo_oe) n_oe++;
    if ((wr_done || rd_done || frame_err) && busy) n_busy_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic bitn(int n, logic [3:0] c, logic [3:0] a, logic [15:0] w);
    if (n < 4)  return c[3-n];
    if (n < 8)  return a[7-n];
    if (n < 10) return 1'b0;
    if (n < 26) return w[25-n];
    return 1'b0;
  endfunction

  // Drops CS_n and clocks nr rising edges; CS_n is left low.
  task automatic spi_frame(input string tag, input logic [3:0] c, input logic [3:0] a,
                           input logic [15:0] w, input int nr, input bit is_rd,
                           output logic [15:0] r);
    int oe_bad = 0;
    r = '0;
    cs_n = 1'b0;
    #HALF;
    for (int n = 0; n < nr; n++) begin
      sdi = bitn(n, c, a, w);
      #HALF;
      if (sdo_oe !== (is_rd && n >= 10)) oe_bad++;
      if (n >= 10 && n < 26) r[25-n] = sdo;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    #HALF;
    chk({tag, "_oe_phase"}, oe_bad, 0);
  endtask

  task automatic cs_high();
    @(negedge gclk) cs_n = 1'b1;
    repeat (10) @(negedge gclk);
  endtask

  task automatic loc_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge gclk);
    loc_wr_en = 1'b1; loc_wr_addr = a; loc_wr_data = d;
    @(negedge gclk);
    loc_wr_en = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    @(negedge gclk) loc_rd_addr = a;
    #1;
    chk(tag, loc_rd_data, exp);
  endtask

  task automatic snap();
    b_wr = n_wr; b_rd = n_rd; b_err = n_err; b_oe = n_oe;
  endtask

  initial begin
    grst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    loc_wr_en = 1'b0; loc_wr_addr = '0; loc_wr_data = '0; loc_rd_addr = '0;
    repeat (4) @(negedge gclk);
    chk("rst_sdo", sdo, 0);
    chk("rst_oe", sdo_oe, 0);
    chk("rst_pulses", {wr_done, rd_done, frame_err, busy}, 4'b0000);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    grst_n = 1'b1;
    reg_chk("rst_reg0", 4'd0, 16'h0000);

    // full-word write
    snap();
    spi_frame("wr_full", 4'b1011, 4'd3, 16'hA5C3, 26, 1'b0, rd);
    chk("wr_full_busy", busy, 1);
    cs_high();
    chk("wr_full_done", n_wr - b_wr, 1);
    chk("wr_full_addr", wr_addr, 3);
    chk("wr_full_data", wr_data, 16'hA5C3);
    reg_chk("wr_full_reg3", 4'd3, 16'hA5C3);

    // read of a locally written register
    loc_wr(4'd5, 16'h1234);
    snap();
    spi_frame("rd", 4'b1010, 4'd5, 16'h0000, 26, 1'b1, rd);
    cs_high();
    chk("rd_data", rd, 16'h1234);
    chk("rd_done", n_rd - b_rd, 1);
    chk("rd_no_wr", n_wr - b_wr, 0);
    chk("rd_oe_after", sdo_oe, 0);

    // short write, 8 bits
    snap();
    spi_frame("wr_short", 4'b1011, 4'd7, 16'hF000, 18, 1'b0, rd);
    cs_high();
    chk("wr_short_done", n_wr - b_wr, 1);
    reg_chk("wr_short_reg7", 4'd7, 16'hF000);

    // unknown command
    snap();
    spi_frame("bad", 4'b1111, 4'd3, 16'h0F0F, 26, 1'b0, rd);
    cs_high();
    chk("bad_err", n_err - b_err, 1);
    chk("bad_no_wr", n_wr - b_wr, 0);
    chk("bad_no_oe", n_oe - b_oe, 0);
    reg_chk("bad_reg3", 4'd3, 16'hA5C3);

    // abort after 6 rises, then a clean frame
    snap();
    spi_frame("abort", 4'b1011, 4'd4, 16'hFFFF, 6, 1'b0, rd);
    cs_high();
    chk("abort_err", n_err - b_err, 1);
    chk("abort_no_wr", n_wr - b_wr, 0);
    reg_chk("abort_reg4", 4'd4, 16'h0000);
    snap();
    spi_frame("post_abort", 4'b1011, 4'd4, 16'h5A5A, 26, 1'b0, rd);
    cs_high();
    chk("post_abort_done", n_wr - b_wr, 1);
    chk("post_abort_err", n_err - b_err, 0);
    reg_chk("post_abort_reg4", 4'd4, 16'h5A5A);

    // collision: local write lands in the same cycle as the SPI commit
    snap();
    spi_frame("coll", 4'b1011, 4'd2, 16'hBEEF, 26, 1'b0, rd);
    @(negedge gclk) cs_n = 1'b1;
    repeat (SYNC) @(posedge gclk);
    @(negedge gclk);
    loc_wr_en = 1'b1; loc_wr_addr = 4'd2; loc_wr_data = 16'h0001;
    @(negedge gclk) loc_wr_en = 1'b0;
    repeat (8) @(negedge gclk);
    chk("coll_done", n_wr - b_wr, 1);
    reg_chk("coll_reg2", 4'd2, 16'hBEEF);

    // reset in the middle of a read
    spi_frame("rst_mid", 4'b1010, 4'd2, 16'h0000, 13, 1'b1, rd);
    chk("rst_mid_oe_before", sdo_oe, 1);
    chk("rst_mid_busy_before", busy, 1);
    grst_n = 1'b0;
    #1;
    chk("rst_mid_sdo", sdo, 0);
    chk("rst_mid_oe", sdo_oe, 0);
    chk("rst_mid_busy", busy, 0);
    cs_n = 1'b1;
    reg_chk("rst_mid_reg2", 4'd2, 16'h0000);
    reg_chk("rst_mid_reg3", 4'd3, 16'h0000);
    reg_chk("rst_mid_reg5", 4'd5, 16'h0000);
    chk("rst_mid_wr_data", wr_data, 0);
    @(negedge gclk) grst_n = 1'b1;
    repeat (8) @(negedge gclk);

    chk("busy_low_in_pulse", n_busy_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end

endmodule
